b07_line_points: RTL and testbench

- Sequential datapath/FSM that scans a fixed 16-entry ROM of 8-bit points.
- Each (x, y) pair is treated as a point; the block counts the pairs that satisfy (3*x + y) mod 256 == 2, i.e. points on a fixed line.
- The count is reported on punti_retta when a scan finishes.
- Standalone benchmark-style control block; a scan is started by a single-bit start request.

---
 rtl/b07_line_points.sv | 119 +++++++++++
 tb/tb_b07_line_points.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/b07_line_points.sv
`default_nettype none
// ============================================================================
// Module      : b07_line_points
// Description : Scans a 16-word point ROM and counts (x,y) pairs lying on
//               the line 3x + y = 2 (mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
module b07_line_points #(
    parameter int LUNG_MEM = 15,
    parameter int DATA_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              __obs,
    output logic [DATA_W-1:0] punti_retta
);

    localparam int ADDR_W = $clog2(LUNG_MEM + 1);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LUNG_MEM);
    localparam logic [DATA_W-1:0] c_on_line   = DATA_W'(2);

    localparam logic [2:0] S_RESET      = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_LOAD_X     = 3'd2;
    localparam logic [2:0] S_UPDATE_MAR = 3'd3;
    localparam logic [2:0] S_LOAD_Y     = 3'd4;
    localparam logic [2:0] S_CALC_RETTA = 3'd5;
    localparam logic [2:0] S_INCREMENT  = 3'd6;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_cont;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_t;
    logic [DATA_W-1:0] r_punti_retta;
    logic [DATA_W-1:0] w_rom;
    logic              w_obs_unused;

    // Debug observation input is deliberately kept out of the datapath.
    assign w_obs_unused = __obs;
    assign punti_retta  = r_punti_retta;

    always_comb begin
        w_rom = '0;
        case (r_mar)
            4'd0:    w_rom = DATA_W'(1);
            4'd1:    w_rom = DATA_W'(255);
            4'd5:    w_rom = DATA_W'(2);
            4'd9:    w_rom = DATA_W'(2);
            4'd10:   w_rom = DATA_W'(255);
            4'd11:   w_rom = DATA_W'(5);
            4'd13:   w_rom = DATA_W'(2);
            4'd15:   w_rom = DATA_W'(2);
            default: w_rom = '0;
        endcase
    end

    // x accumulates x -> 3x -> 3x+y across the per-pair states.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RESET;
            r_cont        <= '0;
            r_mar         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_t           <= '0;
            r_punti_retta <= '0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_START;
                S_START: begin
                    if (start) begin
                        r_cont        <= '0;
                        r_punti_retta <= '0;
                        r_mar         <= '0;
                        r_state       <= S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    r_x     <= w_rom;
                    r_state <= S_UPDATE_MAR;
                end
                S_UPDATE_MAR: begin
                    r_mar   <= r_mar + ADDR_W'(1);
                    r_t     <= {r_x[DATA_W-2:0], 1'b0};
                    r_state <= S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    r_y     <= w_rom;
                    r_x     <= r_x + r_t;
                    r_state <= S_CALC_RETTA;
                end
                S_CALC_RETTA: begin
                    r_x     <= r_x + r_y;
                    r_state <= S_INCREMENT;
                end
                S_INCREMENT: begin
                    if (r_mar != c_last_addr) begin
                        if (r_x == c_on_line) begin
                            r_cont <= r_cont + DATA_W'(1);
                        end
                        r_mar   <= r_mar + ADDR_W'(1);
                        r_state <= S_LOAD_X;
                    end else if (!start) begin
                        // Last pair is folded straight into the published count.
                        r_punti_retta <= (r_x == c_on_line) ? r_cont + DATA_W'(1) : r_cont;
                        r_state       <= S_START;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_b07_line_points.sv
`default_nettype none
// ============================================================================
// Module      : tb_b07_line_points
// Description : Directed self-checking bench for b07_line_points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b07_line_points;

    logic       clock;
    logic       reset;
    logic       start;
    logic       obs;
    logic [7:0] punti_retta;

    int total = 0;
    int bad   = 0;

    b07_line_points #(
        .LUNG_MEM(15),
        .DATA_W  (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .__obs      (obs),
        .punti_retta(punti_retta)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start is accepted on the first edge; result (6 points) appears 40 edges later.
    task automatic run_scan(input string tag, input bit toggle_obs);
        start = 1'b1;
        if (toggle_obs) obs = 1'($urandom);
        tick();
        check({tag, "_accept"}, punti_retta, 8'd0);
        start = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (toggle_obs) obs = 1'($urandom);
            tick();
            check({tag, "_busy"}, punti_retta, 8'd0);
        end
        if (toggle_obs) obs = 1'($urandom);
        tick();
        check({tag, "_result"}, punti_retta, 8'd6);
        for (int i = 0; i < 3; i++) begin
            if (toggle_obs) obs = 1'($urandom);
            tick();
            check({tag, "_hold"}, punti_retta, 8'd6);
        end
        obs = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        obs   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", punti_retta, 8'd0);
        tick();
        tick();
        check("reset_held", punti_retta, 8'd0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", punti_retta, 8'd0);
        end

        run_scan("nominal", 1'b0);
        run_scan("rerun", 1'b0);

        // Held start parks the FSM at the final pair with the output cleared.
        start = 1'b1;
        tick();
        check("held_accept", punti_retta, 8'd0);
        for (int i = 1; i < 50; i++) begin
            tick();
            check("held_park", punti_retta, 8'd0);
        end
        start = 1'b0;
        tick();
        check("held_release", punti_retta, 8'd6);
        tick();
        check("held_after", punti_retta, 8'd6);

        // Asynchronous reset clears a published result without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        check("reset_idle_async", punti_retta, 8'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset partway through a scan, then a fresh scan.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("midscan_before", punti_retta, 8'd0);
        #1;
        reset = 1'b0;
        #1;
        check("midscan_reset", punti_retta, 8'd0);
        tick();
        check("midscan_held", punti_retta, 8'd0);
        reset = 1'b1;
        tick();
        run_scan("after_reset", 1'b0);

        run_scan("obs_toggle", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
